// File: rtl/npu_io_pkg.sv
// Shared types and defaults for the NPU SDRAM I/O path.
// Holds the read scheduler state encoding and engine width/burst defaults.
package npu_io_pkg;

   localparam int SDRAM_W_DEF    = 128;
   localparam int BEAT_BYTES_DEF = SDRAM_W_DEF / 8;
   localparam int MAX_BURST_DEF  = 256;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } rd_state_e;

endpackage

// File: rtl/sdram_read_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr and wraps; zero latency.
// No backpressure of its own; the caller decides when a grant is taken and advances ptr.
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [PTR_W-1:0] gnt_idx
);

   logic [PTR_W-1:0] idx;

   // Walk from the farthest candidate back to ptr so the last hit is the closest to ptr.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = PTR_W'((int'(ptr) + i) % N_REQ);
         if (req[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/sdram_read_sched.sv
// Splits per-requester read transfers into engine bursts and routes returned beats back.
// Accept/done pulses and response routing are zero latency; one transfer in flight at a time.
module sdram_read_sched
   import npu_io_pkg::*;
#(
   parameter int SDRAM_W   = SDRAM_W_DEF,
   parameter int N_REQ     = 2,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0][31:0] req_addr,
   input  logic [N_REQ-1:0][15:0] req_len,
   output logic [N_REQ-1:0]       req_ready,
   output logic [N_REQ-1:0]       resp_valid,
   output logic [SDRAM_W-1:0]     resp_data,
   output logic [15:0]            resp_beat,
   output logic                   resp_last,
   output logic [N_REQ-1:0]       req_done,
   output logic [31:0]            eng_read_addr,
   output logic [10:0]            eng_read_cnt,
   output logic                   eng_read_start,
   input  logic                   eng_out_valid,
   input  logic [10:0]            eng_out_idx,
   input  logic [SDRAM_W-1:0]     eng_out_data
);

   localparam int BEAT_BYTES = SDRAM_W / 8;
   localparam int PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   rd_state_e        state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [31:0]      cur_addr_q, cur_addr_d;
   logic [15:0]      remaining_q, remaining_d;
   logic [15:0]      beat_q, beat_d;
   logic [10:0]      burst_cnt_q, burst_cnt_d;
   logic [10:0]      burst_len_q, burst_len_d;

   logic [N_REQ-1:0] arb_gnt;
   logic [PTR_W-1:0] arb_idx;
   logic [N_REQ-1:0] ready_c, done_c;
   logic [10:0]      issue_cnt;
   logic [10:0]      burst_cnt_inc;
   logic [15:0]      rem_after_beat;
   logic             in_wait, in_issue, beat_in;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign in_wait        = (state_q == WAIT_DATA);
   assign in_issue       = (state_q == ISSUE);
   assign beat_in        = in_wait && eng_out_valid;
   assign issue_cnt      = (remaining_q > 16'(MAX_BURST)) ? 11'(MAX_BURST) : remaining_q[10:0];
   assign burst_cnt_inc  = burst_cnt_q + 11'd1;
   assign rem_after_beat = remaining_q - 16'(burst_cnt_inc);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      beat_d      = beat_q;
      burst_cnt_d = burst_cnt_q;
      burst_len_d = burst_len_q;
      ready_c     = '0;
      done_c      = '0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               ready_c     = arb_gnt;
               rr_ptr_d    = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);
               beat_d      = '0;
               burst_cnt_d = '0;
               // An empty transfer completes on the spot and never touches the engine.
               if (req_len[arb_idx] == 16'd0) begin
                  done_c = arb_gnt;
               end else begin
                  state_d     = ISSUE;
                  gnt_d       = arb_gnt;
                  cur_addr_d  = req_addr[arb_idx];
                  remaining_d = req_len[arb_idx];
               end
            end
         end
         ISSUE: begin
            burst_len_d = issue_cnt;
            state_d     = WAIT_DATA;
         end
         WAIT_DATA: begin
            if (eng_out_valid) begin
               beat_d = beat_q + 16'd1;
               if (burst_cnt_inc == burst_len_q) begin
                  burst_cnt_d = '0;
                  remaining_d = remaining_q - 16'(burst_len_q);
                  cur_addr_d  = cur_addr_q + 32'(burst_len_q) * 32'(BEAT_BYTES);
                  if (rem_after_beat == 16'd0) begin
                     done_c  = gnt_q;
                     state_d = IDLE;
                  end else begin
                     state_d = ISSUE;
                  end
               end else begin
                  burst_cnt_d = burst_cnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         beat_q      <= '0;
         burst_cnt_q <= '0;
         burst_len_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         beat_q      <= beat_d;
         burst_cnt_q <= burst_cnt_d;
         burst_len_q <= burst_len_d;
      end
   end

   // The accept path is combinational from req_valid, so hold it quiet while in reset.
   assign req_ready      = rst_n ? ready_c : '0;
   assign req_done       = rst_n ? done_c : '0;
   assign resp_valid     = in_wait ? (gnt_q & {N_REQ{eng_out_valid}}) : '0;
   assign resp_data      = beat_in ? eng_out_data : '0;
   assign resp_beat      = beat_q;
   assign resp_last      = beat_in && (rem_after_beat == 16'd0);
   assign eng_read_start = in_issue;
   assign eng_read_addr  = in_issue ? cur_addr_q : '0;
   assign eng_read_cnt   = in_issue ? issue_cnt : '0;

   a_eng_idx : assert property (@(posedge clk) disable iff (!rst_n)
      beat_in |-> (eng_out_idx == burst_cnt_q));

endmodule

// File: tb/tb_sdram_read_sched.sv
// Scoreboard bench for sdram_read_sched with a behavioural burst read engine.
// Expected starts, beats and handshakes are queued when a request is driven.
module tb_sdram_read_sched;

   localparam int W = 128;

   typedef struct {
      logic [31:0] addr;
      logic [10:0] cnt;
   } start_t;

   typedef struct {
      int          port;
      logic [15:0] beat;
      logic [W-1:0] data;
      logic        last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0][31:0] req_addr;
   logic [1:0][15:0] req_len;
   logic [1:0]      req_ready;
   logic [1:0]      resp_valid;
   logic [W-1:0]    resp_data;
   logic [15:0]     resp_beat;
   logic            resp_last;
   logic [1:0]      req_done;
   logic [31:0]     eng_read_addr;
   logic [10:0]     eng_read_cnt;
   logic            eng_read_start;
   logic            eng_out_valid;
   logic [10:0]     eng_out_idx;
   logic [W-1:0]    eng_out_data;

   logic            model_v, stray_v;
   logic [10:0]     model_idx;
   logic [W-1:0]    model_data, stray_data;

   start_t exp_start_q[$];
   beat_t  exp_beat_q[$];
   int     exp_ready_q[$];
   int     exp_done_q[$];
   start_t es;
   beat_t  eb;
   int     ep;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int beats_seen = 0, done_seen = 0, starts_seen = 0;
   int last_ready_cyc = -1, last_done_cyc = -1, last_last_cyc = -1;

   assign eng_out_valid = model_v | stray_v;
   assign eng_out_idx   = model_idx;
   assign eng_out_data  = stray_v ? stray_data : model_data;

   sdram_read_sched #(
      .SDRAM_W   (W),
      .N_REQ     (2),
      .MAX_BURST (256)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_len        (req_len),
      .req_ready      (req_ready),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .resp_beat      (resp_beat),
      .resp_last      (resp_last),
      .req_done       (req_done),
      .eng_read_addr  (eng_read_addr),
      .eng_read_cnt   (eng_read_cnt),
      .eng_read_start (eng_read_start),
      .eng_out_valid  (eng_out_valid),
      .eng_out_idx    (eng_out_idx),
      .eng_out_data   (eng_out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] mkdata(input logic [31:0] a);
      return {4{a}};
   endfunction

   function automatic logic [1:0] onehot(input int p);
      return 2'b01 << p;
   endfunction

   // Queue everything a request should produce: accept, bursts, beats, completion.
   function automatic void push_expect(input int p, input logic [31:0] a, input int len);
      int          rem;
      logic [31:0] ba;
      start_t      s;
      beat_t       b;
      exp_ready_q.push_back(p);
      rem = len;
      ba  = a;
      while (rem > 0) begin
         s.addr = ba;
         s.cnt  = 11'((rem > 256) ? 256 : rem);
         exp_start_q.push_back(s);
         ba  = ba + 32'(s.cnt) * 32'd16;
         rem = rem - int'(s.cnt);
      end
      for (int k = 0; k < len; k++) begin
         b.port = p;
         b.beat = 16'(k);
         b.data = mkdata(a + 32'(k) * 32'd16);
         b.last = (k == len - 1);
         exp_beat_q.push_back(b);
      end
      exp_done_q.push_back(p);
   endfunction

   // Behavioural engine: one idle cycle after start, then cnt back-to-back beats.
   initial begin : engine
      logic [31:0] ea;
      int          ec;
      model_v    = 1'b0;
      model_idx  = '0;
      model_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n && eng_read_start) begin
            ea = eng_read_addr;
            ec = int'(eng_read_cnt);
            @(posedge clk);
            #1;
            for (int i = 0; i < ec && rst_n; i++) begin
               model_v    = 1'b1;
               model_idx  = 11'(i);
               model_data = mkdata(ea + 32'(i) * 32'd16);
               @(posedge clk);
               #1;
            end
            model_v = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (eng_read_start) begin
            starts_seen++;
            n_checks++;
            if (exp_start_q.size() == 0) begin
               $display("FAIL start_unexpected addr=%h cnt=%0d required=none", eng_read_addr, eng_read_cnt);
            end else begin
               es = exp_start_q.pop_front();
               if (eng_read_addr !== es.addr || eng_read_cnt !== es.cnt)
                  $display("FAIL start addr=%h cnt=%0d required addr=%h cnt=%0d",
                           eng_read_addr, eng_read_cnt, es.addr, es.cnt);
               else n_pass++;
            end
         end
         if (resp_valid !== 2'b00) begin
            beats_seen++;
            n_checks++;
            if (resp_last === 1'b1) last_last_cyc = cyc;
            if (exp_beat_q.size() == 0) begin
               $display("FAIL beat_unexpected vld=%b beat=%0d required=none", resp_valid, resp_beat);
            end else begin
               eb = exp_beat_q.pop_front();
               if (resp_valid !== onehot(eb.port) || resp_beat !== eb.beat ||
                   resp_data !== eb.data || resp_last !== eb.last)
                  $display("FAIL beat vld=%b beat=%0d last=%b data=%h required vld=%b beat=%0d last=%b data=%h",
                           resp_valid, resp_beat, resp_last, resp_data,
                           onehot(eb.port), eb.beat, eb.last, eb.data);
               else n_pass++;
            end
         end else if (resp_last !== 1'b0) begin
            n_checks++;
            $display("FAIL resp_last_alone last=%b required=0", resp_last);
         end
         if (req_ready !== 2'b00) begin
            last_ready_cyc = cyc;
            n_checks++;
            if (exp_ready_q.size() == 0) begin
               $display("FAIL ready_unexpected ready=%b required=none", req_ready);
            end else begin
               ep = exp_ready_q.pop_front();
               if (req_ready !== onehot(ep))
                  $display("FAIL ready ready=%b required=%b", req_ready, onehot(ep));
               else n_pass++;
            end
         end
         if (req_done !== 2'b00) begin
            done_seen++;
            last_done_cyc = cyc;
            n_checks++;
            if (exp_done_q.size() == 0) begin
               $display("FAIL done_unexpected done=%b required=none", req_done);
            end else begin
               ep = exp_done_q.pop_front();
               if (req_done !== onehot(ep))
                  $display("FAIL done done=%b required=%b", req_done, onehot(ep));
               else n_pass++;
            end
         end
      end
   end

   task automatic drive_req(input int p, input logic [31:0] a, input logic [15:0] l);
      bit seen = 1'b0;
      @(posedge clk);
      #1;
      req_valid[p] = 1'b1;
      req_addr[p]  = a;
      req_len[p]   = l;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (req_ready[p] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) $display("FAIL accept_timeout port=%0d ready=0 required=1", p);
      else n_pass++;
      @(posedge clk);
      #1;
      req_valid[p] = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 5000 && done_seen < target; i++) @(posedge clk);
      n_checks++;
      if (done_seen < target) $display("FAIL done_timeout seen=%0d required=%0d", done_seen, target);
      else n_pass++;
      repeat (2) @(posedge clk);
   endtask

   task automatic check_drained(input string name);
      n_checks++;
      if (exp_start_q.size() != 0 || exp_beat_q.size() != 0 ||
          exp_ready_q.size() != 0 || exp_done_q.size() != 0)
         $display("FAIL drained_%s left starts=%0d beats=%0d ready=%0d done=%0d required=0",
                  name, exp_start_q.size(), exp_beat_q.size(), exp_ready_q.size(), exp_done_q.size());
      else n_pass++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({req_ready, resp_valid, req_done, resp_last, eng_read_start} !== 8'h00)
         $display("FAIL reset_ctrl ready=%b vld=%b done=%b last=%b start=%b required=0",
                  req_ready, resp_valid, req_done, resp_last, eng_read_start);
      else n_pass++;
      n_checks++;
      if (eng_read_addr !== 32'h0 || eng_read_cnt !== 11'h0 || resp_beat !== 16'h0 || resp_data !== '0)
         $display("FAIL reset_data addr=%h cnt=%0d beat=%0d data=%h required=0",
                  eng_read_addr, eng_read_cnt, resp_beat, resp_data);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      int d0 = done_seen;
      push_expect(0, 32'h1000, 4);
      drive_req(0, 32'h1000, 16'd4);
      wait_done(d0 + 1);
      n_checks++;
      if (last_done_cyc - last_last_cyc < 0 || last_done_cyc - last_last_cyc > 1)
         $display("FAIL single_done_timing done_cyc=%0d last_cyc=%0d required gap 0..1",
                  last_done_cyc, last_last_cyc);
      else n_pass++;
      check_drained("single");
   endtask

   task automatic test_stray;
      int d0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         stray_v    = 1'b1;
         stray_data = {4{32'hDEAD_0000 + 32'(i)}};
         @(negedge clk);
         n_checks++;
         if (resp_valid !== 2'b00 || resp_last !== 1'b0 || eng_read_start !== 1'b0)
            $display("FAIL stray vld=%b last=%b start=%b required=0", resp_valid, resp_last, eng_read_start);
         else n_pass++;
      end
      @(posedge clk);
      #1;
      stray_v = 1'b0;
      d0 = done_seen;
      push_expect(1, 32'h0000_5000, 2);
      drive_req(1, 32'h0000_5000, 16'd2);
      wait_done(d0 + 1);
      check_drained("stray");
   endtask

   task automatic test_split;
      int d0 = done_seen;
      push_expect(0, 32'h0, 600);
      drive_req(0, 32'h0, 16'd600);
      wait_done(d0 + 1);
      check_drained("split");
   endtask

   task automatic test_zero_len;
      int d0 = done_seen;
      int s0 = starts_seen;
      exp_ready_q.push_back(1);
      exp_done_q.push_back(1);
      drive_req(1, 32'h0000_7000, 16'd0);
      wait_done(d0 + 1);
      n_checks++;
      if (last_ready_cyc !== last_done_cyc)
         $display("FAIL zero_same_cycle ready_cyc=%0d done_cyc=%0d required equal", last_ready_cyc, last_done_cyc);
      else n_pass++;
      n_checks++;
      if (starts_seen !== s0)
         $display("FAIL zero_no_start starts=%0d required=%0d", starts_seen, s0);
      else n_pass++;
      check_drained("zero");
   endtask

   task automatic test_contention;
      int d0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int r = 0; r < 2; r++) begin
         d0 = done_seen;
         push_expect(0, 32'h4000 + 32'(r) * 32'h100, 3);
         push_expect(1, 32'h8000 + 32'(r) * 32'h100, 2);
         fork
            drive_req(0, 32'h4000 + 32'(r) * 32'h100, 16'd3);
            drive_req(1, 32'h8000 + 32'(r) * 32'h100, 16'd2);
         join
         wait_done(d0 + 2);
      end
      check_drained("contention");
   endtask

   task automatic test_reset_mid;
      int b0 = beats_seen;
      int d0;
      push_expect(0, 32'h0002_0000, 64);
      drive_req(0, 32'h0002_0000, 16'd64);
      for (int i = 0; i < 2000 && beats_seen < b0 + 10; i++) @(posedge clk);
      n_checks++;
      if (beats_seen < b0 + 10) $display("FAIL mid_beats seen=%0d required=%0d", beats_seen - b0, 10);
      else n_pass++;
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, req_done, resp_last, eng_read_start} !== 8'h00 || resp_data !== '0)
         $display("FAIL mid_reset_ctrl ready=%b vld=%b done=%b last=%b start=%b required=0",
                  req_ready, resp_valid, req_done, resp_last, eng_read_start);
      else n_pass++;
      n_checks++;
      if (resp_beat !== 16'h0 || eng_read_addr !== 32'h0 || eng_read_cnt !== 11'h0)
         $display("FAIL mid_reset_data beat=%0d addr=%h cnt=%0d required=0", resp_beat, eng_read_addr, eng_read_cnt);
      else n_pass++;
      exp_start_q.delete();
      exp_beat_q.delete();
      exp_ready_q.delete();
      exp_done_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_seen;
      push_expect(0, 32'h0003_0000, 2);
      drive_req(0, 32'h0003_0000, 16'd2);
      wait_done(d0 + 1);
      check_drained("reset_mid");
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog passed=%0d total=%0d required completion", n_pass, n_checks);
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_addr   = '0;
      req_len    = '0;
      stray_v    = 1'b0;
      stray_data = '0;
      test_reset();
      test_single();
      test_stray();
      test_split();
      test_zero_len();
      test_contention();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sdram_read_sched.md
SDRAM_READ_SCHED -- requirements
Module: sdram_read_sched

Interface
REQ-001 SHALL have parameter SDRAM_W, default 128, engine data width in bits.
REQ-002 SHALL have parameter N_REQ, default 2, number of requesters.
REQ-003 SHALL have parameter MAX_BURST, default 256, maximum beats per engine burst (1..1024).
REQ-004 SHALL have port clk  input  1  clock; reset rst_n, asynchronous, active-low.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester transfer request.
REQ-007 SHALL have port req_addr  input  N_REQ x 32  per-requester byte base address, 16-byte aligned.
REQ-008 SHALL have port req_len  input  N_REQ x 16  per-requester length in beats.
REQ-009 SHALL have port req_ready  output  N_REQ  one-cycle accept pulse, one-hot.
REQ-010 SHALL have port resp_valid  output  N_REQ  data beat valid for the granted requester.
REQ-011 SHALL have port resp_data  output  SDRAM_W  beat data, shared by all requesters.
REQ-012 SHALL have port resp_beat  output  16  beat index within the whole transfer.
REQ-013 SHALL have port resp_last  output  1  final beat of the transfer.
REQ-014 SHALL have port req_done  output  N_REQ  one-cycle completion pulse.
REQ-015 SHALL have ports eng_read_addr (output 32), eng_read_cnt (output 11) and eng_read_start (output 1), driving the burst read engine.
REQ-016 SHALL have ports eng_out_valid (input 1), eng_out_idx (input 11) and eng_out_data (input SDRAM_W), returned from the burst read engine.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT_DATA; IDLE->ISSUE on grant, ISSUE->WAIT_DATA after one cycle, WAIT_DATA->ISSUE or IDLE on the last beat of a burst.
REQ-018 SHALL, in IDLE with any req_valid, grant round-robin starting at rr_ptr, pulse req_ready[g], latch addr/len, then set rr_ptr=(g+1) mod N_REQ.
REQ-019 SHALL, in ISSUE, assert eng_read_start for exactly one cycle with eng_read_addr=cur_addr and eng_read_cnt=min(remaining, MAX_BURST).
REQ-020 SHALL count eng_out_valid beats in WAIT_DATA; on beat count == burst cnt, subtract cnt from remaining and add cnt*SDRAM_W/8 to cur_addr (32-bit, wraps modulo 2^32).
REQ-021 SHALL, at burst end with remaining>0, return to ISSUE on the next cycle; with remaining==0, pulse req_done[g] that cycle and return to IDLE.
REQ-022 SHALL drive resp_valid[g]=eng_out_valid only in WAIT_DATA, combinationally (zero latency), with resp_data=eng_out_data.
REQ-023 SHALL assert resp_last on the beat where remaining-after-beat == 0, and hold resp_beat as a 16-bit running count, reset on each grant.
REQ-024 SHALL accept req_len==0 by pulsing req_ready and req_done in the same cycle, issuing no engine start, staying in IDLE.
REQ-025 SHALL ignore eng_out_valid outside WAIT_DATA (no resp_valid, no counter change).
REQ-026 SHALL not grant again until req_done of the current transfer; req_valid changes during a transfer have no effect.
REQ-027 SHALL check eng_out_idx against the local beat count and raise no output on mismatch (debug assertion only).

Reset
REQ-028 SHALL, on rst_n low at any time, go to IDLE, clear rr_ptr, counters, cur_addr and remaining, and drive all outputs to 0; an in-flight transfer is abandoned without req_done.

Structure
REQ-029 SHALL place the state enum and the SDRAM_W, BEAT_BYTES=SDRAM_W/8 and MAX_BURST defaults in shared package npu_io_pkg.
REQ-030 SHALL contain one sub-module rr_arbiter (N_REQ-wide round-robin, one-hot grant); everything else is flat.

Verification
REQ-031 Single request: port0 addr 0x1000, len 4 -> one start with addr 0x1000, cnt 4; four resp_valid[0] beats; resp_last on beat 3; req_done[0] one cycle later than or with the last beat.
REQ-032 Split: len 600, MAX_BURST 256 -> starts at 0x0/256, 0x1000/256, 0x2000/88; resp_beat runs 0..599 contiguously.
REQ-033 Contention: both ports valid at once from reset -> port0 served first, then port1; next simultaneous pair -> port0 again (rr_ptr wraps).
REQ-034 Zero length: port1 len 0 -> req_ready[1] and req_done[1] in the same cycle; no eng_read_start.
REQ-035 Reset mid-transfer: rst_n low after 10 of 64 beats -> outputs 0 immediately; after release, a new 2-beat request completes normally.
REQ-036 Stray data: eng_out_valid pulsed in IDLE -> no resp_valid, no counter change.
